// File: rtl/request_encoder_8_to_3_if.sv
// Request/grant bus of the 8-to-3 request encoder: request capture controls
// from the control unit, encoded index and pending state back from the encoder.
interface request_encoder_8_to_3_if;
  logic [0:7] request;
  logic       enable;
  logic       clear_all;
  logic       ready;
  logic [2:0] binary;
  logic       valid;
  logic [0:7] pending;

  modport master (
    output request, enable, clear_all, ready,
    input  binary, valid, pending
  );

  modport slave (
    input  request, enable, clear_all, ready,
    output binary, valid, pending
  );
endinterface

// File: rtl/request_encoder_8_to_3.sv
// Sequential 8-to-3 encoder: sticky pending register feeding a valid/ready
// index stream, fixed or round-robin priority selected by ROUND_ROBIN.
module request_encoder_8_to_3 #(
  parameter bit ROUND_ROBIN = 1'b0
) (
  input logic                    clock,
  input logic                    reset_n,
  request_encoder_8_to_3_if.slave bus
);

  typedef enum logic {IDLE, VALID} state_t;

  state_t     state_q, state_d;
  logic [0:7] pending_q, pending_d;
  logic [2:0] binary_q, binary_d;
  logic [2:0] ptr_q, ptr_d;
  logic       valid_q, valid_d;
  logic [0:7] capture;
  logic [0:7] grant_mask;
  logic [0:7] rem;

  // Lowest set index of vec at or after start, wrapping 7 -> 0.
  function automatic logic [2:0] pick(input logic [0:7] vec, input logic [2:0] start);
    logic [2:0] idx;
    logic [2:0] result;
    result = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      idx = start + 3'(i);
      if (vec[idx]) result = idx;
    end
    return result;
  endfunction

  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latches).
    capture        = bus.enable ? bus.request : '0;
    grant_mask     = '0;
    grant_mask[binary_q] = 1'b1;
    rem            = pending_q & ~grant_mask;
    state_d        = state_q;
    pending_d      = pending_q | capture;
    binary_d       = binary_q;
    valid_d        = valid_q;
    ptr_d          = ptr_q;

    case (state_q)
      IDLE: begin
        // Selection uses the pre-edge pending only; same-edge captures wait a cycle.
        if (pending_q != '0) begin
          state_d  = VALID;
          valid_d  = 1'b1;
          binary_d = pick(pending_q, ROUND_ROBIN ? ptr_q : 3'd0);
        end
      end
      VALID: begin
        if (bus.ready) begin
          // Capture is OR-ed after the clear, so a same-edge request re-arms the granted bit.
          pending_d = rem | capture;
          ptr_d     = binary_q + 3'd1;
          if (rem != '0) begin
            binary_d = pick(rem, ROUND_ROBIN ? (binary_q + 3'd1) : 3'd0);
          end else begin
            state_d  = IDLE;
            valid_d  = 1'b0;
            binary_d = 3'd0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Flush overrides captures and handshakes but leaves the rotation pointer alone.
    if (bus.clear_all) begin
      pending_d = '0;
      state_d   = IDLE;
      valid_d   = 1'b0;
      binary_d  = 3'd0;
      ptr_d     = ptr_q;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      binary_q  <= 3'd0;
      valid_q   <= 1'b0;
      ptr_q     <= 3'd0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q   <= state_d;
      pending_q <= pending_d;
      binary_q  <= binary_d;
      valid_q   <= valid_d;
      ptr_q     <= ptr_d;
    end
  end

  assign bus.binary  = binary_q;
  assign bus.valid   = valid_q;
  assign bus.pending = pending_q;

endmodule

// File: tb/tb_request_encoder_8_to_3.sv
// Directed bench for request_encoder_8_to_3: one fixed-priority and one
// round-robin instance, grant order tracked through an expected-index queue.
module tb_request_encoder_8_to_3;

  logic clock;
  logic reset_n;
  int   total;
  int   bad;
  logic [2:0] exp_q[$];

  request_encoder_8_to_3_if fx_if();
  request_encoder_8_to_3_if rr_if();

  request_encoder_8_to_3 #(.ROUND_ROBIN(1'b0)) dut_fx (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (fx_if.slave)
  );

  request_encoder_8_to_3 #(.ROUND_ROBIN(1'b1)) dut_rr (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (rr_if.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Sample point one time unit after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_fx(input logic [0:7] req, input logic en, input logic clr, input logic rdy);
    fx_if.request   = req;
    fx_if.enable    = en;
    fx_if.clear_all = clr;
    fx_if.ready     = rdy;
  endtask

  task automatic drive_rr(input logic [0:7] req, input logic en, input logic clr, input logic rdy);
    rr_if.request   = req;
    rr_if.enable    = en;
    rr_if.clear_all = clr;
    rr_if.ready     = rdy;
  endtask

  // Compare a presented index against the oldest outstanding expectation.
  task automatic expect_grant(input string tag, input logic v, input logic [2:0] b);
    logic [2:0] exp;
    check({tag, "_valid"}, 8'(v), 8'd1);
    check({tag, "_queued"}, 8'(exp_q.size() > 0 ? 1 : 0), 8'd1);
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      check({tag, "_index"}, 8'(b), 8'(exp));
    end
  endtask

  task automatic grant_fx(input string tag);
    expect_grant(tag, fx_if.valid, fx_if.binary);
  endtask

  task automatic grant_rr(input string tag);
    expect_grant(tag, rr_if.valid, rr_if.binary);
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    reset_n = 1'b0;
    drive_fx('0, 1'b0, 1'b0, 1'b0);
    drive_rr('0, 1'b0, 1'b0, 1'b0);

    // Reset state
    #12;
    check("rst_pending", 8'(fx_if.pending), 8'h00);
    check("rst_valid",   8'(fx_if.valid),   8'd0);
    check("rst_binary",  8'(fx_if.binary),  8'd0);
    check("rst_rr_valid", 8'(rr_if.valid),  8'd0);
    reset_n = 1'b1;

    // Basic: index 2, held while ready=0, then accepted
    drive_fx(8'b00100000, 1'b1, 1'b0, 1'b0);
    tick();
    drive_fx('0, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(3'd2);
    check("t1_pending", 8'(fx_if.pending), 8'b00100000);
    check("t1_not_yet_valid", 8'(fx_if.valid), 8'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t1_hold_valid",  8'(fx_if.valid),  8'd1);
      check("t1_hold_binary", 8'(fx_if.binary), 8'd2);
    end
    drive_fx('0, 1'b0, 1'b0, 1'b1);
    grant_fx("t1_grant");
    tick();
    drive_fx('0, 1'b0, 1'b0, 1'b0);
    check("t1_done_valid",   8'(fx_if.valid),   8'd0);
    check("t1_done_binary",  8'(fx_if.binary),  8'd0);
    check("t1_done_pending", 8'(fx_if.pending), 8'h00);

    // Fixed priority back-to-back: 0, 3, 7 with ready held high
    drive_fx(8'b10010001, 1'b1, 1'b0, 1'b1);
    tick();
    drive_fx('0, 1'b0, 1'b0, 1'b1);
    exp_q.push_back(3'd0);
    exp_q.push_back(3'd3);
    exp_q.push_back(3'd7);
    check("t2_pending", 8'(fx_if.pending), 8'b10010001);
    check("t2_idle_ready_ignored", 8'(fx_if.valid), 8'd0);
    tick();
    grant_fx("t2_g0");
    tick();
    grant_fx("t2_g1");
    tick();
    grant_fx("t2_g2");
    tick();
    drive_fx('0, 1'b0, 1'b0, 1'b0);
    check("t2_done_valid",   8'(fx_if.valid),   8'd0);
    check("t2_done_pending", 8'(fx_if.pending), 8'h00);

    // Round-robin: grant 6, then 7 and 1 wrap, then pointer at 2 favours 2 over 1
    drive_rr(8'b00000010, 1'b1, 1'b0, 1'b0);
    tick();
    drive_rr('0, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(3'd6);
    tick();
    drive_rr('0, 1'b0, 1'b0, 1'b1);
    grant_rr("t3_g6");
    tick();
    drive_rr(8'b01000001, 1'b1, 1'b0, 1'b0);
    check("t3_after6_valid", 8'(rr_if.valid), 8'd0);
    tick();
    drive_rr('0, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(3'd7);
    exp_q.push_back(3'd1);
    tick();
    drive_rr('0, 1'b0, 1'b0, 1'b1);
    grant_rr("t3_g7");
    tick();
    grant_rr("t3_g1_wrap");
    tick();
    drive_rr(8'b01100000, 1'b1, 1'b0, 1'b0);
    check("t3_idle_valid", 8'(rr_if.valid), 8'd0);
    tick();
    drive_rr('0, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(3'd2);
    exp_q.push_back(3'd1);
    tick();
    drive_rr('0, 1'b0, 1'b0, 1'b1);
    grant_rr("t3_ptr2_g2");
    tick();
    grant_rr("t3_ptr3_g1");
    tick();
    drive_rr('0, 1'b0, 1'b0, 1'b0);
    check("t3_done_valid",   8'(rr_if.valid),   8'd0);
    check("t3_done_pending", 8'(rr_if.pending), 8'h00);

    // Set beats clear on index 4
    drive_fx(8'b00001000, 1'b1, 1'b0, 1'b0);
    tick();
    drive_fx('0, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(3'd4);
    tick();
    drive_fx(8'b00001000, 1'b1, 1'b0, 1'b1);
    grant_fx("t4_first");
    exp_q.push_back(3'd4);
    tick();
    drive_fx('0, 1'b0, 1'b0, 1'b0);
    check("t4_rearmed_pending", 8'(fx_if.pending), 8'b00001000);
    check("t4_bubble_valid",    8'(fx_if.valid),   8'd0);
    tick();
    drive_fx('0, 1'b0, 1'b0, 1'b1);
    grant_fx("t4_again");
    tick();
    drive_fx('0, 1'b0, 1'b0, 1'b0);
    check("t4_done_valid",   8'(fx_if.valid),   8'd0);
    check("t4_done_pending", 8'(fx_if.pending), 8'h00);

    // clear_all overrides capture and handshake; enable=0 blocks capture
    drive_fx(8'hFF, 1'b1, 1'b0, 1'b0);
    tick();
    drive_fx('0, 1'b0, 1'b0, 1'b0);
    check("t5_full_pending", 8'(fx_if.pending), 8'hFF);
    tick();
    check("t5_full_valid",  8'(fx_if.valid),  8'd1);
    check("t5_full_binary", 8'(fx_if.binary), 8'd0);
    drive_fx(8'h01, 1'b1, 1'b1, 1'b1);
    tick();
    drive_fx('0, 1'b0, 1'b0, 1'b0);
    check("t5_clr_pending", 8'(fx_if.pending), 8'h00);
    check("t5_clr_valid",   8'(fx_if.valid),   8'd0);
    check("t5_clr_binary",  8'(fx_if.binary),  8'd0);
    tick();
    check("t5_clr_no_capture", 8'(fx_if.pending), 8'h00);
    drive_fx(8'h80, 1'b0, 1'b0, 1'b0);
    tick();
    drive_fx('0, 1'b0, 1'b0, 1'b0);
    check("t5_disabled_pending", 8'(fx_if.pending), 8'h00);
    tick();
    check("t5_disabled_valid", 8'(fx_if.valid), 8'd0);

    // Asynchronous reset with a grant in flight
    drive_fx(8'b00000110, 1'b1, 1'b0, 1'b0);
    tick();
    drive_fx('0, 1'b0, 1'b0, 1'b0);
    tick();
    check("t6_pre_valid",   8'(fx_if.valid),   8'd1);
    check("t6_pre_binary",  8'(fx_if.binary),  8'd5);
    check("t6_pre_pending", 8'(fx_if.pending), 8'b00000110);
    #2 reset_n = 1'b0;
    #1;
    check("t6_async_pending", 8'(fx_if.pending), 8'h00);
    check("t6_async_valid",   8'(fx_if.valid),   8'd0);
    check("t6_async_binary",  8'(fx_if.binary),  8'd0);
    #3 reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t6_idle_valid",   8'(fx_if.valid),   8'd0);
      check("t6_idle_pending", 8'(fx_if.pending), 8'h00);
    end
    drive_fx(8'b00010000, 1'b1, 1'b0, 1'b0);
    tick();
    drive_fx('0, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(3'd3);
    tick();
    drive_fx('0, 1'b0, 1'b0, 1'b1);
    grant_fx("t6_recover");
    tick();
    drive_fx('0, 1'b0, 1'b0, 1'b0);
    check("t6_recover_done", 8'(fx_if.valid), 8'd0);

    check("scoreboard_empty", 8'(exp_q.size()), 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
